// File: rtl/aes_uart_tx_serializer_if.sv
// Handshake bundle between the AES core result port and the UART serializer.
// The master side is the core (word producer); the slave side is the serializer.
interface aes_uart_tx_serializer_if #(
    parameter int DATA_W = 112
);
    logic              valid;
    logic [DATA_W-1:0] data_in;
    logic              tx;
    logic              busy;
    logic              done;

    modport master (
        output valid,
        output data_in,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  valid,
        input  data_in,
        output tx,
        output busy,
        output done
    );
endinterface

// File: rtl/aes_uart_tx_serializer.sv
// Captures one AES result word and sends it MSB-byte first as back-to-back 8N1
// UART frames; busy covers the whole word, done pulses after the final stop bit.
module aes_uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_BYTES    = 14,
    parameter int DATA_W       = 112
) (
    input  logic                     clk,
    input  logic                     reset,
    aes_uart_tx_serializer_if.slave  bus
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [7:0] cur_byte;
    logic       baud_end;

    // The byte on the wire always sits in the top 8 bits of the shift register.
    assign cur_byte = shreg_q[DATA_W-1 -: 8];
    assign baud_end = (baud_q == BAUD_LAST);

    // tx_d is the line level for the next cycle, so tx leaves a flop glitch-free.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (bus.valid) begin
                    state_d = START;
                    shreg_d = bus.data_in;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    baud_d  = '0;
                    bit_d   = '0;
                    idx_d   = '0;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = cur_byte[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_byte[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (idx_q != IDX_LAST) begin
                        // Next byte starts immediately: no idle gap between bytes.
                        idx_d   = idx_q + IDX_W'(1);
                        shreg_d = shreg_q << 8;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_aes_uart_tx_serializer.sv
// Bench for aes_uart_tx_serializer: ideal UART waveform model plus a receiver
// that decodes the line, against a fast-baud instance and a default-baud one.
module tb_aes_uart_tx_serializer;
    localparam int C     = 4;
    localparam int CD    = 868;
    localparam int NB    = 14;
    localparam int DW    = 112;
    localparam int FRAME = NB * 10 * C;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   tests_run    = 0;
    int   tests_failed = 0;

    logic       samp[$];
    logic       bsamp[$];
    int         done_at[$];
    logic [7:0] rx[$];

    aes_uart_tx_serializer_if #(.DATA_W(DW)) ifa ();
    aes_uart_tx_serializer_if #(.DATA_W(DW)) ifb ();

    aes_uart_tx_serializer #(.CLKS_PER_BIT(C), .NUM_BYTES(NB), .DATA_W(DW)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (ifa)
    );

    aes_uart_tx_serializer #(.CLKS_PER_BIT(CD), .NUM_BYTES(NB), .DATA_W(DW)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (ifb)
    );

    always #5 clk = ~clk;

    // Ideal line level k cycles after the first start bit begins.
    function automatic logic ref_bit(input logic [DW-1:0] w, input int c, input int k);
        int b;
        int pos;
        logic [7:0] by;
        b   = k / (10 * c);
        pos = (k % (10 * c)) / c;
        if (b >= NB) return 1'b1;
        by = 8'(w >> (8 * (NB - 1 - b)));
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return by[pos-1];
    endfunction

    function automatic logic [7:0] ref_byte(input logic [DW-1:0] w, input int b);
        return 8'(w >> (8 * (NB - 1 - b)));
    endfunction

    function automatic logic [DW-1:0] rand_word();
        return DW'({$urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    // Receiver: find a low start bit, sample each data bit mid-cell.
    task automatic decode(input int c);
        int i;
        logic [7:0] by;
        rx.delete();
        i = 0;
        while (i + 9 * c + c / 2 < samp.size()) begin
            if (samp[i] === 1'b0) begin
                for (int j = 0; j < 8; j++) by[j] = samp[i + c / 2 + c * (j + 1)];
                rx.push_back(by);
                i = i + c / 2 + 9 * c;
            end else begin
                i++;
            end
        end
    endtask

    // Launch a word on dut_a and record n cycles starting at the first start-bit cycle.
    task automatic record(input logic [DW-1:0] w, input int n, input int inj0, input int inj1);
        samp.delete();
        bsamp.delete();
        done_at.delete();
        ifa.valid   = 1'b1;
        ifa.data_in = w;
        @(negedge clk);
        ifa.valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            samp.push_back(ifa.tx);
            bsamp.push_back(ifa.busy);
            if (ifa.done === 1'b1) done_at.push_back(k);
            if (k == inj0 || k == inj1) begin
                ifa.valid   = 1'b1;
                ifa.data_in = '1;
            end else begin
                ifa.valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int bad_tx = 0;
        int bad_busy = 0;
        int bad_done = 0;
        rst_a = 1'b1;
        for (int k = 0; k < 10; k++) begin
            ifa.valid   = k[0];
            ifa.data_in = rand_word();
            @(negedge clk);
            if (ifa.tx !== 1'b1) bad_tx++;
            if (ifa.busy !== 1'b0) bad_busy++;
            if (ifa.done !== 1'b0) bad_done++;
        end
        ifa.valid = 1'b0;
        ifb.valid = 1'b0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (ifa.tx !== 1'b1) bad_tx++;
            if (ifa.busy !== 1'b0) bad_busy++;
            if (ifa.done !== 1'b0) bad_done++;
        end
        tests_run++;
        if (bad_tx != 0) begin tests_failed++; $display("FAIL reset_tx: %0d cycles tx!=1, required 0", bad_tx); end
        tests_run++;
        if (bad_busy != 0) begin tests_failed++; $display("FAIL reset_busy: %0d cycles busy!=0, required 0", bad_busy); end
        tests_run++;
        if (bad_done != 0) begin tests_failed++; $display("FAIL reset_done: %0d cycles done!=0, required 0", bad_done); end
        tests_run++;
        if (ifb.tx !== 1'b1 || ifb.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_b_idle: tx=%b busy=%b, required tx=1 busy=0", ifb.tx, ifb.busy);
        end
    endtask

    task automatic test_single();
        logic [DW-1:0] w = 112'h00112233445566778899AABBCCDD;
        int bad = 0;
        int first_low = -1;
        int hi = 0;
        record(w, FRAME + 20, -1, -1);
        for (int k = 0; k < samp.size(); k++) if (samp[k] !== ref_bit(w, C, k)) bad++;
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL single_wave: %0d cycles differ, required 0", bad); end
        decode(C);
        tests_run++;
        if (rx.size() != NB) begin tests_failed++; $display("FAIL single_nbytes: got %0d, required %0d", rx.size(), NB); end
        for (int b = 0; b < NB && b < rx.size(); b++) begin
            tests_run++;
            if (rx[b] !== ref_byte(w, b)) begin
                tests_failed++;
                $display("FAIL single_byte%0d: got %h, required %h", b, rx[b], ref_byte(w, b));
            end
        end
        tests_run++;
        if (done_at.size() != 1 || done_at[0] != FRAME) begin
            tests_failed++;
            $display("FAIL single_done: %0d pulses first at %0d, required 1 at %0d",
                     done_at.size(), (done_at.size() > 0) ? done_at[0] : -1, FRAME);
        end
        for (int k = 0; k < bsamp.size(); k++) begin
            if (bsamp[k] === 1'b1) hi++;
            else if (first_low < 0) first_low = k;
        end
        tests_run++;
        if (first_low != FRAME || hi != FRAME) begin
            tests_failed++;
            $display("FAIL single_busy: fell at %0d high %0d cycles, required %0d/%0d", first_low, hi, FRAME, FRAME);
        end
    endtask

    task automatic test_ignore_busy();
        logic [DW-1:0] w;
        int bad = 0;
        int bad_bytes = 0;
        w = rand_word();
        record(w, FRAME + 40, 50, 300);
        for (int k = 0; k < samp.size(); k++) if (samp[k] !== ref_bit(w, C, k)) bad++;
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL ignore_wave: %0d cycles differ, required 0", bad); end
        decode(C);
        for (int b = 0; b < NB; b++) if (b >= rx.size() || rx[b] !== ref_byte(w, b)) bad_bytes++;
        tests_run++;
        if (bad_bytes != 0 || rx.size() != NB) begin
            tests_failed++;
            $display("FAIL ignore_bytes: %0d wrong of %0d decoded, required 0 of %0d", bad_bytes, rx.size(), NB);
        end
        tests_run++;
        if (done_at.size() != 1 || done_at[0] != FRAME) begin
            tests_failed++;
            $display("FAIL ignore_done: %0d pulses, required 1 at %0d", done_at.size(), FRAME);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] w1;
        logic [DW-1:0] wm;
        logic [DW-1:0] w2;
        logic exp;
        int bad = 0;
        int bad_bytes = 0;
        int n = 2 * FRAME + 20;
        w1 = rand_word();
        wm = rand_word();
        w2 = rand_word();
        samp.delete();
        done_at.delete();
        ifa.valid   = 1'b1;
        ifa.data_in = w1;
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            samp.push_back(ifa.tx);
            if (ifa.done === 1'b1) done_at.push_back(k);
            if (k == 100) ifa.data_in = wm;
            if (k == FRAME) ifa.data_in = w2;
            if (k == 2 * FRAME) ifa.valid = 1'b0;
            @(negedge clk);
        end
        ifa.valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k < FRAME) exp = ref_bit(w1, C, k);
            else if (k == FRAME) exp = 1'b1;
            else exp = ref_bit(w2, C, k - FRAME - 1);
            if (samp[k] !== exp) bad++;
        end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL b2b_wave: %0d cycles differ, required 0", bad); end
        tests_run++;
        if (samp[FRAME] !== 1'b1 || samp[FRAME+1] !== 1'b0 || samp[FRAME-1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_gap: around gap %b%b%b, required 110", samp[FRAME-1], samp[FRAME], samp[FRAME+1]);
        end
        decode(C);
        for (int b = 0; b < 2 * NB; b++) begin
            if (b >= rx.size()) bad_bytes++;
            else if (rx[b] !== ((b < NB) ? ref_byte(w1, b) : ref_byte(w2, b - NB))) bad_bytes++;
        end
        tests_run++;
        if (bad_bytes != 0 || rx.size() != 2 * NB) begin
            tests_failed++;
            $display("FAIL b2b_bytes: %0d wrong of %0d decoded, required 0 of %0d", bad_bytes, rx.size(), 2 * NB);
        end
        tests_run++;
        if (done_at.size() != 2 || done_at[0] != FRAME || done_at[1] != 2 * FRAME + 1) begin
            tests_failed++;
            $display("FAIL b2b_done: %0d pulses, required 2 at %0d and %0d", done_at.size(), FRAME, 2 * FRAME + 1);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] w = 112'h00112233445566778899AABBCCDD;
        logic [DW-1:0] w2;
        int kr = 5 * 10 * C + 4 * C + 1;
        int bad_idle = 0;
        int bad = 0;
        ifa.valid   = 1'b1;
        ifa.data_in = w;
        @(negedge clk);
        ifa.valid = 1'b0;
        for (int k = 0; k < kr; k++) @(negedge clk);
        tests_run++;
        if (ifa.tx !== ref_bit(w, C, kr)) begin
            tests_failed++;
            $display("FAIL mid_pre_tx: got %b, required %b", ifa.tx, ref_bit(w, C, kr));
        end
        rst_a = 1'b1;
        #1;
        tests_run++;
        if (ifa.tx !== 1'b1 || ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_async: tx=%b busy=%b done=%b, required 1 0 0", ifa.tx, ifa.busy, ifa.done);
        end
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            if (ifa.tx !== 1'b1 || ifa.busy !== 1'b0 || ifa.done !== 1'b0) bad_idle++;
        end
        tests_run++;
        if (bad_idle != 0) begin tests_failed++; $display("FAIL mid_no_resume: %0d non-idle cycles, required 0", bad_idle); end
        w2 = rand_word();
        record(w2, FRAME + 10, -1, -1);
        for (int k = 0; k < samp.size(); k++) if (samp[k] !== ref_bit(w2, C, k)) bad++;
        tests_run++;
        if (bad != 0 || done_at.size() != 1 || done_at[0] != FRAME) begin
            tests_failed++;
            $display("FAIL mid_next_frame: %0d cycles differ, %0d done pulses, required 0 and 1", bad, done_at.size());
        end
    endtask

    task automatic test_default_baud();
        logic [DW-1:0] w = {NB{8'hA5}};
        int n = 2 * 10 * CD + CD;
        int low_run = 0;
        int bad = 0;
        int bad_busy = 0;
        int dones = 0;
        samp.delete();
        ifb.valid   = 1'b1;
        ifb.data_in = w;
        @(negedge clk);
        ifb.valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            samp.push_back(ifb.tx);
            if (ifb.busy !== 1'b1) bad_busy++;
            if (ifb.done === 1'b1) dones++;
            @(negedge clk);
        end
        while (low_run < samp.size() && samp[low_run] === 1'b0) low_run++;
        tests_run++;
        if (low_run != CD) begin tests_failed++; $display("FAIL dflt_start_len: low %0d cycles, required %0d", low_run, CD); end
        for (int k = 0; k < n; k++) if (samp[k] !== ref_bit(w, CD, k)) bad++;
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL dflt_wave: %0d cycles differ, required 0", bad); end
        decode(CD);
        tests_run++;
        if (rx.size() < 2 || rx[0] !== 8'hA5 || rx[1] !== 8'hA5) begin
            tests_failed++;
            $display("FAIL dflt_bytes: decoded %0d bytes first %h, required >=2 of a5",
                     rx.size(), (rx.size() > 0) ? rx[0] : 8'h00);
        end
        tests_run++;
        if (bad_busy != 0 || dones != 0) begin
            tests_failed++;
            $display("FAIL dflt_busy: %0d busy-low cycles %0d dones mid-frame, required 0 and 0", bad_busy, dones);
        end
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
    endtask

    initial begin
        rst_a       = 1'b1;
        rst_b       = 1'b1;
        ifa.valid   = 1'b0;
        ifa.data_in = '0;
        ifb.valid   = 1'b0;
        ifb.data_in = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_default_baud();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
